sr_imem_loader: RTL
===================

Name: sr_imem_loader

Overview:
- Instruction memory for the single-cycle core, with a built-in byte-stream program loader.
- It sits directly upstream of the CPU: it answers the CPU's word-address fetch port combinationally.
- It accepts a length-prefixed byte stream over a valid/ready handshake, assembles little-endian words and writes them into memory.
- While a program is being loaded it holds the CPU in reset through cpuRst, then releases it.

Parameters:
DEPTH, 64, number of 32-bit instruction words stored (power of two, 4..4096)
ADDR_W, $clog2(DEPTH), internal word index width (derived, not overridden)

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
imAddr  input  32  CPU word address (byte PC >> 2)
imData  output  32  instruction word at imAddr
ldValid  input  1  loader byte valid
ldData  input  8  loader byte
ldReady  output  1  loader can accept a byte this cycle
load  input  1  one-cycle request to restart loading
cpuRst  output  1  reset to the CPU; high while loading
loadedWords  output  16  words written by the current/last load
loadErr  output  1  sticky error for the current/last load

Behaviour:
- Reset is asynchronous and active-high on rst. Reset values:
  - state = LEN_LO
  - cpuRst = 1
  - ldReady = 1
  - loadedWords = 0
  - loadErr = 0
  - byte counter = 0, word count = 0
  - Memory contents are not reset.
- A byte transfer occurs on a rising clk edge with ldValid && ldReady.
- ldReady = (state != RUN) && !load.
- Stream format:
  - LEN_LO, LEN_HI: word count N, little-endian 16 bits.
  - DATA: then N*4 bytes, each word little-endian (first byte -> bits 7:0).
- States:
  - LEN_LO: on transfer, latch N[7:0] -> LEN_HI.
  - LEN_HI: on transfer, latch N[15:8]. If the full N is 0 -> RUN (CHECK if the option is enabled); else -> DATA.
  - DATA:
    - Shift bytes into a 24-bit assembly register.
    - On the 4th byte of a word, write {byte, asm} to mem[loadedWords] on that same edge and increment loadedWords.
    - After word N is written -> RUN (CHECK if the option is enabled).
  - RUN: cpuRst = 0, ldReady = 0.
- Overflow:
  - If N > DEPTH, set loadErr at the LEN_HI transfer.
  - Words with index >= DEPTH are consumed but not written.
  - loadedWords still counts to N; the CPU is still released.
- cpuRst is registered:
  - It goes low in the cycle after the edge that transfers the final byte.
  - It goes high on the edge where load is sampled high.
- load, sampled high in any state:
  - Next state LEN_LO; clear byte counter, loadedWords and loadErr; cpuRst = 1.
  - A byte presented in the same cycle is not accepted (ldReady is low).
- Read port:
  - Combinational: imData = mem[imAddr[ADDR_W-1:0]] when imAddr < DEPTH.
  - Otherwise imData = 32'h00000013 (addi x0,x0,0 NOP).
- Writes are visible on imData the cycle after the writing edge.
- Words not rewritten by a shorter load keep their previous values.

Optional Feature:
- Macro: SR_IMEM_LOADER_CHECKSUM_EN.
- Enabled:
  - An extra state CHECK follows DATA (or LEN_HI when N = 0) and accepts one checksum byte.
  - The checksum is the XOR of all DATA bytes; it is 8'h00 when N = 0.
  - Match -> RUN.
  - Mismatch -> set loadErr and go to LEN_LO. cpuRst stays 1, loadedWords holds its value until the next LEN_HI, and already-written words remain.
- Disabled: no CHECK state; the final data byte goes directly to RUN.

Test Plan:
- Reset, then stream 02 00 | 13 05 10 00 | 93 05 20 00 -> mem[0]=32'h00100513, mem[1]=32'h00200593, loadedWords=2. cpuRst falls the cycle after the last byte; imAddr=1 gives 32'h00200593.
- Bytes with ldValid toggling every other cycle, plus 1-cycle gaps -> identical memory contents; no byte lost or duplicated.
- Header 00 00 -> RUN after 2 transfers (or 3 with the checksum byte 00 when enabled); loadedWords=0; previous memory is preserved.
- DEPTH=4, N=5 -> loadErr=1 after LEN_HI; mem[0..3] written, 5th word dropped; loadedWords=5; cpuRst releases.
- load pulse mid-DATA, with ldValid high in the same cycle -> that byte is not accepted. Next state LEN_LO, cpuRst=1 on the next cycle, loadErr=0, and a fresh load succeeds.
- imAddr=DEPTH and imAddr=32'hFFFFFFFF -> imData=32'h00000013. With CHECKSUM_EN, a wrong checksum -> loadErr=1, cpuRst stays 1, state LEN_LO.

Source files
------------

// File: rtl/sr_imem_loader.sv
// Instruction memory with a length-prefixed little-endian byte-stream loader that holds the CPU in reset while loading.
// Optional trailing XOR checksum byte is enabled with `define SR_IMEM_LOADER_CHECKSUM_EN.
module sr_imem_loader #(
    parameter int DEPTH = 64,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] imAddr,
    output logic [31:0] imData,
    input  logic        ldValid,
    input  logic [7:0]  ldData,
    output logic        ldReady,
    input  logic        load,
    output logic        cpuRst,
    output logic [15:0] loadedWords,
    output logic        loadErr
);

`ifdef SR_IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        LEN_LO = 3'd0,
        LEN_HI = 3'd1,
        DATA   = 3'd2,
        RUN    = 3'd3,
        CHECK  = 3'd4
    } loadState_t;
`else
    typedef enum logic [2:0] {
        LEN_LO = 3'd0,
        LEN_HI = 3'd1,
        DATA   = 3'd2,
        RUN    = 3'd3
    } loadState_t;
`endif

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    logic [31:0] mem [DEPTH];

    loadState_t  state_r;
    logic [7:0]  lenLo_r;
    logic [15:0] wordTarget_r;
    logic [1:0]  byteCnt_r;
    logic [23:0] asm_r;
`ifdef SR_IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  csum_r;
`endif

    logic        xfer_s;
    logic        wordDone_s;
    logic        lastWord_s;
    logic        wrEn_s;
    logic [15:0] lenFull_s;

    assign ldReady    = (state_r != RUN) && !load;
    assign xfer_s     = ldValid && ldReady;
    assign lenFull_s  = {ldData, lenLo_r};
    assign wordDone_s = xfer_s && (state_r == DATA) && (byteCnt_r == 2'd3);
    assign lastWord_s = (loadedWords + 16'd1) == wordTarget_r;
    // Words past the end of memory are still counted but never written.
    assign wrEn_s     = wordDone_s && (loadedWords < 16'(DEPTH));

    // Loader state machine, word bookkeeping and CPU reset control.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= LEN_LO;
            lenLo_r      <= 8'h00;
            wordTarget_r <= 16'h0000;
            byteCnt_r    <= 2'd0;
            asm_r        <= 24'h00_0000;
            loadedWords  <= 16'h0000;
            loadErr      <= 1'b0;
            cpuRst       <= 1'b1;
`ifdef SR_IMEM_LOADER_CHECKSUM_EN
            csum_r       <= 8'h00;
`endif
        end else if (load) begin
            state_r     <= LEN_LO;
            byteCnt_r   <= 2'd0;
            loadedWords <= 16'h0000;
            loadErr     <= 1'b0;
            cpuRst      <= 1'b1;
`ifdef SR_IMEM_LOADER_CHECKSUM_EN
            csum_r      <= 8'h00;
`endif
        end else begin
            case (state_r)
                LEN_LO: begin
                    if (xfer_s) begin
                        lenLo_r <= ldData;
                        state_r <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (xfer_s) begin
                        wordTarget_r <= lenFull_s;
                        loadedWords  <= 16'h0000;
                        byteCnt_r    <= 2'd0;
                        loadErr      <= (lenFull_s > 16'(DEPTH));
`ifdef SR_IMEM_LOADER_CHECKSUM_EN
                        csum_r       <= 8'h00;
                        state_r      <= (lenFull_s == 16'h0000) ? CHECK : DATA;
`else
                        if (lenFull_s == 16'h0000) begin
                            state_r <= RUN;
                            cpuRst  <= 1'b0;
                        end else begin
                            state_r <= DATA;
                        end
`endif
                    end
                end
                DATA: begin
                    if (xfer_s) begin
                        byteCnt_r <= byteCnt_r + 2'd1;
                        asm_r     <= {ldData, asm_r[23:8]};
`ifdef SR_IMEM_LOADER_CHECKSUM_EN
                        csum_r    <= csum_r ^ ldData;
`endif
                        if (byteCnt_r == 2'd3) begin
                            loadedWords <= loadedWords + 16'd1;
                            if (lastWord_s) begin
`ifdef SR_IMEM_LOADER_CHECKSUM_EN
                                state_r <= CHECK;
`else
                                state_r <= RUN;
                                cpuRst  <= 1'b0;
`endif
                            end
                        end
                    end
                end
`ifdef SR_IMEM_LOADER_CHECKSUM_EN
                CHECK: begin
                    if (xfer_s) begin
                        if (ldData == csum_r) begin
                            state_r <= RUN;
                            cpuRst  <= 1'b0;
                        end else begin
                            // Failed image: keep the CPU in reset and wait for a fresh header.
                            loadErr <= 1'b1;
                            state_r <= LEN_LO;
                        end
                    end
                end
`endif
                RUN: begin
                    state_r <= RUN;
                end
                default: begin
                    state_r <= LEN_LO;
                    cpuRst  <= 1'b1;
                end
            endcase
        end
    end

    // Memory write port; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (wrEn_s) begin
            mem[loadedWords[ADDR_W-1:0]] <= {ldData, asm_r};
        end
    end

    // Combinational fetch port; out-of-range fetches return a NOP.
    always_comb begin
        imData = NOP_INSN;
        if (imAddr < 32'(DEPTH)) begin
            imData = mem[imAddr[ADDR_W-1:0]];
        end else begin
            imData = NOP_INSN;
        end
    end

endmodule
